// File: rtl/sdram_init_seq.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_init_seq
//  Description : SDRAM power-up initialisation sequencer with re-init support.
//                It issues this sequence: power-up wait, PRECHARGE-ALL,
//                REF_NUM x AUTO-REFRESH, then LOAD MODE REGISTER. It then
//                parks in DONE with NOP on the bus. A reinit_req seen in DONE
//                replays the sequence without the power-up wait.
//  Ports       : sclk/s_rst_n      system clock, sync active-low reset
//                sdram_clk         inverted sclk to the device
//                mode_val          mode word, latched when a sequence starts
//                reinit_req/ack    re-init request level / completion pulse
//                sdram_cke/cmd/addr/bank  registered SDRAM command bus
//                init_done         high while parked in DONE
//                ref_cnt           AUTO-REFRESH commands in current sequence
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_init_seq #(
  parameter int ADDR_W  = 12,
  parameter int BA_W    = 2,
  parameter int T_PWR   = 10000,
  parameter int T_RP    = 3,
  parameter int T_RFC   = 7,
  parameter int T_MRD   = 2,
  parameter int REF_NUM = 2
) (
  input  logic              sclk,
  input  logic              s_rst_n,
  output logic              sdram_clk,
  input  logic [ADDR_W-1:0] mode_val,
  input  logic              reinit_req,
  output logic              reinit_ack,
  output logic              sdram_cke,
  output logic [3:0]        sdram_cmd,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [BA_W-1:0]   sdram_bank,
  output logic              init_done,
  output logic [3:0]        ref_cnt
);

  localparam logic [3:0] C_CMD_NOP = 4'b0111;
  localparam logic [3:0] C_CMD_PRE = 4'b0010;
  localparam logic [3:0] C_CMD_REF = 4'b0001;
  localparam logic [3:0] C_CMD_MRS = 4'b0000;

  // One shared counter covers the power-up wait and all command gaps.
  localparam int C_T_MAX_A = (T_PWR > T_RP)  ? T_PWR : T_RP;
  localparam int C_T_MAX_B = (T_RFC > T_MRD) ? T_RFC : T_MRD;
  localparam int C_T_MAX   = (C_T_MAX_A > C_T_MAX_B) ? C_T_MAX_A : C_T_MAX_B;
  localparam int CNT_W     = $clog2(C_T_MAX);

  // The command state takes one cycle, so each wait state lasts T-1 cycles
  // and it exits when the counter reaches T-2.
  localparam logic [CNT_W-1:0] C_PWR_LAST = CNT_W'(T_PWR - 1);
  localparam logic [CNT_W-1:0] C_RP_LAST  = CNT_W'(T_RP - 2);
  localparam logic [CNT_W-1:0] C_RFC_LAST = CNT_W'(T_RFC - 2);
  localparam logic [CNT_W-1:0] C_MRD_LAST = CNT_W'(T_MRD - 2);

  localparam logic [ADDR_W-1:0] C_ADDR_A10 = ADDR_W'(1024);
  localparam logic [3:0]        C_REF_NUM  = 4'(REF_NUM);

  typedef enum logic [2:0] {
    S_WAIT_PWR = 3'd0,
    S_PRE      = 3'd1,
    S_WAIT_RP  = 3'd2,
    S_REF      = 3'd3,
    S_WAIT_RFC = 3'd4,
    S_MRS      = 3'd5,
    S_WAIT_MRD = 3'd6,
    S_DONE     = 3'd7
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [3:0]        ref_cnt_q;
  logic [3:0]        ref_cnt_d;
  logic [ADDR_W-1:0] mode_q;
  logic              reinit_q;    // current sequence is a re-init
  logic [3:0]        cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BA_W-1:0]   bank_q;
  logic              cke_q;
  logic              done_q;
  logic              ack_q;

  // Saturating refresh count, applied on the edge that registers AUTO_REF.
  assign ref_cnt_d = (ref_cnt_q == C_REF_NUM) ? ref_cnt_q : ref_cnt_q + 4'd1;

  always_ff @(posedge sclk) begin
    if (!s_rst_n) begin
      state_q   <= S_WAIT_PWR;
      cnt_q     <= '0;
      ref_cnt_q <= '0;
      mode_q    <= '0;
      reinit_q  <= 1'b0;
      cmd_q     <= C_CMD_NOP;
      addr_q    <= '0;
      bank_q    <= '0;
      cke_q     <= 1'b0;
      done_q    <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      // Bus defaults to NOP; only command-issuing transitions override it.
      cke_q  <= 1'b1;
      cmd_q  <= C_CMD_NOP;
      addr_q <= '0;
      bank_q <= '0;
      ack_q  <= 1'b0;
      case (state_q)
        S_WAIT_PWR: begin
          if (cnt_q == C_PWR_LAST) begin
            mode_q  <= mode_val;
            state_q <= S_PRE;
            cmd_q   <= C_CMD_PRE;
            addr_q  <= C_ADDR_A10;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_PRE: state_q <= S_WAIT_RP;
        S_WAIT_RP: begin
          if (cnt_q == C_RP_LAST) begin
            state_q   <= S_REF;
            cmd_q     <= C_CMD_REF;
            ref_cnt_q <= ref_cnt_d;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_REF: state_q <= S_WAIT_RFC;
        S_WAIT_RFC: begin
          if (cnt_q == C_RFC_LAST) begin
            cnt_q <= '0;
            if (ref_cnt_q < C_REF_NUM) begin
              state_q   <= S_REF;
              cmd_q     <= C_CMD_REF;
              ref_cnt_q <= ref_cnt_d;
            end else begin
              state_q <= S_MRS;
              cmd_q   <= C_CMD_MRS;
              addr_q  <= mode_q;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_MRS: state_q <= S_WAIT_MRD;
        S_WAIT_MRD: begin
          if (cnt_q == C_MRD_LAST) begin
            state_q  <= S_DONE;
            done_q   <= 1'b1;
            ack_q    <= reinit_q;
            reinit_q <= 1'b0;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          // While ack is showing, a requester may still hold req; ignore it
          // so one request yields exactly one sequence.
          if (reinit_req && !ack_q) begin
            mode_q    <= mode_val;
            state_q   <= S_PRE;
            cmd_q     <= C_CMD_PRE;
            addr_q    <= C_ADDR_A10;
            done_q    <= 1'b0;
            ref_cnt_q <= '0;
            reinit_q  <= 1'b1;
            cnt_q     <= '0;
          end
        end
        default: state_q <= S_WAIT_PWR;
      endcase
    end
  end

  assign sdram_clk  = ~sclk;
  assign reinit_ack = ack_q;
  assign sdram_cke  = cke_q;
  assign sdram_cmd  = cmd_q;
  assign sdram_addr = addr_q;
  assign sdram_bank = bank_q;
  assign init_done  = done_q;
  assign ref_cnt    = ref_cnt_q;

endmodule
`default_nettype wire
